// File: rtl/bmult_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bmult_arb_pkg
//  Description : Shared types and constants for the Bmult8x8 sharing arbiter.
//                The requester-id type is sized for the largest supported
//                requester count, so one tag format serves every build.
//  Revision    : 1.0 - initial release
// ============================================================================
package bmult_arb_pkg;

    localparam int NUM_REQ_MAX = 16;
    localparam int W_DEF       = 8;
    localparam int PROD_W      = 2 * W_DEF;
    localparam int ID_W        = $clog2(NUM_REQ_MAX);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // Round-robin successor of a requester id, wrapping at n.
    function automatic req_id_t rr_next(input req_id_t id, input int n);
        if (int'(id) + 1 >= n) begin
            return '0;
        end
        return req_id_t'(int'(id) + 1);
    endfunction

endpackage : bmult_arb_pkg
`default_nettype wire

// File: rtl/bmult8x8_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Combinational search for the first
//                asserted request starting at the pointer; the pointer moves
//                to winner+1 on a grant and holds otherwise.
//  Ports       : clk, rst_n        clock / async active-low reset
//                req_i             request vector (already qualified)
//                gnt_o             one-hot (or zero) grant
//                gnt_valid_o       a grant is issued this cycle
//                gnt_id_o          index of the winner
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import bmult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output req_id_t            gnt_id_o
);

    req_id_t ptr_q;
    req_id_t ptr_d;
    logic    found;
    int      win;
    int      pos;

    always_comb begin
        found = 1'b0;
        win   = 0;
        pos   = 0;
        // Visit positions ptr, ptr+1, ... (mod NUM_REQ); the inner loop keeps
        // every select of req_i on a plain loop index.
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr_q) + k) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req_i[j] && (j == pos)) begin
                    found = 1'b1;
                    win   = j;
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt_o[j] = found && (win == j);
        end
        gnt_valid_o = found;
        gnt_id_o    = req_id_t'(win);
        ptr_d       = found ? rr_next(req_id_t'(win), NUM_REQ) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bmult8x8_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bmult8x8_arbiter
//  Description : Shares one external Bmult8x8 multiplier among NUM_REQ
//                requesters. Round-robin issue of at most one operation per
//                cycle, registered operands, a tag pipeline that follows each
//                operation through the multiplier, and one result slot per
//                requester. A busy bit per requester allows only one
//                outstanding operation, so a result slot is always free when
//                its product arrives.
//  Ports       : clk, rst_n            clock / async active-low reset
//                req_valid_i/ready_o   operand handshake, one bit per requester
//                req_a_i, req_b_i      operands, requester i at [i*W +: W]
//                rsp_valid_o/ready_i   result handshake, one bit per requester
//                rsp_p_o               products, requester i at [i*2W +: 2W]
//                mult_a_o, mult_b_o    registered operands to the multiplier
//                mult_p_i              product from the multiplier
//  Revision    : 1.0 - initial release
// ============================================================================
module bmult8x8_arbiter
    import bmult_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int W        = W_DEF,
    parameter int MULT_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*W-1:0]   req_a_i,
    input  logic [NUM_REQ*W-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    input  logic [NUM_REQ-1:0]     rsp_ready_i,
    output logic [NUM_REQ*2*W-1:0] rsp_p_o,
    output logic [W-1:0]           mult_a_o,
    output logic [W-1:0]           mult_b_o,
    input  logic [2*W-1:0]         mult_p_i
);

    localparam int PW = 2 * W;

    logic [NUM_REQ-1:0]    busy_q, busy_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*PW-1:0] rsp_p_q, rsp_p_d;
    logic [W-1:0]          mult_a_q, mult_a_d;
    logic [W-1:0]          mult_b_q, mult_b_d;
    tag_t                  tag_q [MULT_LAT];
    tag_t                  tag_out;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    gnt;
    logic                  gnt_valid;
    req_id_t               gnt_id;

    // Gating with rst_n keeps req_ready low while reset is held, even if a
    // requester is already presenting operands.
    assign eligible = req_valid_i & ~busy_q & {NUM_REQ{rst_n}};

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (eligible),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // The last tag stage is valid exactly when mult_p_i carries its product.
    assign tag_out = tag_q[MULT_LAT-1];

    always_comb begin
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mult_a_d = req_a_i[i*W +: W];
                mult_b_d = req_b_i[i*W +: W];
            end
        end
    end

    always_comb begin
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid_q[i] && rsp_ready_i[i]) begin
                rsp_valid_d[i] = 1'b0;
                busy_d[i]      = 1'b0;
            end
            if (gnt[i]) begin
                busy_d[i] = 1'b1;
            end
            if (tag_out.valid && (int'(tag_out.id) == i)) begin
                rsp_valid_d[i]          = 1'b1;
                rsp_p_d[i*PW +: PW]     = mult_p_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MULT_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].valid <= gnt_valid;
            tag_q[0].id    <= gnt_id;
            for (int k = 1; k < MULT_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign req_ready_o = gnt;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_p_o     = rsp_p_q;
    assign mult_a_o    = mult_a_q;
    assign mult_b_o    = mult_b_q;

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready_o));
    a_ready_not_busy : assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready_o & busy_q) == '0);
    a_no_overwrite : assert property (@(posedge clk) disable iff (!rst_n)
        tag_out.valid |-> ((rsp_valid_q & ~rsp_ready_i) >> tag_out.id) == '0 ||
                          !rsp_valid_q[tag_out.id[$clog2(NUM_REQ)-1:0]]);
`endif

endmodule : bmult8x8_arbiter
`default_nettype wire

// File: tb/tb_bmult8x8_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bmult8x8_arbiter
//  Description : Self-checking bench for bmult8x8_arbiter with a single-cycle
//                (combinational-output) multiplier model, MULT_LAT = 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bmult8x8_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int W        = 8;
    localparam int MULT_LAT = 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*W-1:0]   req_a;
    logic [NUM_REQ*W-1:0]   req_b;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ-1:0]     rsp_ready;
    logic [NUM_REQ*2*W-1:0] rsp_p;
    logic [W-1:0]           mult_a;
    logic [W-1:0]           mult_b;
    logic [2*W-1:0]         mult_p;

    always #5 clk = ~clk;

    // External multiplier: output valid in the same cycle as its operands.
    assign mult_p = {8'b0, mult_a} * {8'b0, mult_b};

    bmult8x8_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .W           (W),
        .MULT_LAT    (MULT_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_p_o     (rsp_p),
        .mult_a_o    (mult_a),
        .mult_b_o    (mult_b),
        .mult_p_i    (mult_p)
    );

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [6];
    int   total = 0;
    int   bad   = 0;
    int   g0;
    int   got;
    int   seq [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{0, 8'd13,  8'd11,  16'd143};
        vecs[1] = '{1, 8'hFF,  8'hFF,  16'hFE01};
        vecs[2] = '{2, 8'h00,  8'hFF,  16'h0000};
        vecs[3] = '{3, 8'd200, 8'd3,   16'd600};
        vecs[4] = '{0, 8'd128, 8'd2,   16'd256};
        vecs[5] = '{2, 8'd1,   8'd1,   16'd1};

        do_reset();
        chk("rst_ready",  64'(req_ready), 64'd0);
        chk("rst_rspv",   64'(rsp_valid), 64'd0);
        chk("rst_rspp",   64'(rsp_p),     64'd0);
        chk("rst_multa",  64'(mult_a),    64'd0);

        // Single operations from the vector table.
        for (int v = 0; v < 6; v++) begin
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            #1;
            chk("op_grant", 64'(req_ready), 64'(1 << vecs[v].id));
            step();
            req_valid[vecs[v].id] = 1'b0;
            chk("op_multa", 64'(mult_a), 64'(vecs[v].a));
            chk("op_multb", 64'(mult_b), 64'(vecs[v].b));
            chk("op_early", 64'(rsp_valid), 64'd0);
            step();
            chk("op_rspv", 64'(rsp_valid), 64'(1 << vecs[v].id));
            chk("op_rspp", 64'(rsp_p[vecs[v].id*16 +: 16]), 64'(vecs[v].p));
            step();
            chk("op_clear", 64'(rsp_valid), 64'd0);
            chk("op_hold",  64'(rsp_p[vecs[v].id*16 +: 16]), 64'(vecs[v].p));
        end

        // Contention: all four valid from reset.
        do_reset();
        for (int c = 0; c < 4; c++) set_op(c, 8'(c + 2), 8'(c + 5));
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("cont_gnt", 64'(req_ready), 64'(1 << c));
            step();
            if (c == 0) begin
                chk("cont_rspv", 64'(rsp_valid), 64'd0);
            end else begin
                chk("cont_rspv", 64'(rsp_valid), 64'(1 << (c - 1)));
                chk("cont_rspp", 64'(rsp_p[(c-1)*16 +: 16]), 64'((c + 1) * (c + 4)));
            end
            req_valid[c] = 1'b0;
            #1;
        end
        step();
        chk("cont_rspv3", 64'(rsp_valid), 64'b1000);
        chk("cont_rspp3", 64'(rsp_p[3*16 +: 16]), 64'd40);

        // Back-pressure on requester 2.
        do_reset();
        rsp_ready[2] = 1'b0;
        set_op(2, 8'd7, 8'd9);
        #1;
        chk("bp_first", 64'(req_ready), 64'b0100);
        step();
        set_op(0, 8'd2, 8'd3);
        #1;
        g0 = 0;
        for (int n = 0; n < 10; n++) begin
            chk("bp_no_gnt2", 64'(req_ready[2]), 64'd0);
            if (req_ready[0]) g0++;
            step();
        end
        chk("bp_g0", 64'(g0), 64'd4);
        chk("bp_rspv2", 64'(rsp_valid[2]), 64'd1);
        chk("bp_rspp2", 64'(rsp_p[2*16 +: 16]), 64'd63);
        req_valid[0] = 1'b0;
        rsp_ready[2] = 1'b1;
        #1;
        chk("bp_rel_same", 64'(req_ready), 64'd0);
        step();
        chk("bp_rel_next", 64'(req_ready), 64'b0100);
        chk("bp_rspv2_off", 64'(rsp_valid[2]), 64'd0);

        // Fairness between requesters 1 and 3.
        do_reset();
        set_op(1, 8'd3, 8'd3);
        set_op(3, 8'd4, 8'd4);
        #1;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready != '0 && got < 4) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (req_ready[j]) seq[got] = j;
                end
                got++;
            end
            step();
        end
        chk("fair_count", 64'(got), 64'd4);
        if (got == 4) begin
            chk("fair_g0", 64'(seq[0]), 64'd1);
            chk("fair_g1", 64'(seq[1]), 64'd3);
            chk("fair_g2", 64'(seq[2]), 64'd1);
            chk("fair_g3", 64'(seq[3]), 64'd3);
        end

        // Asynchronous reset with an operation in flight.
        do_reset();
        set_op(0, 8'd13, 8'd11);
        step();
        req_valid[0] = 1'b0;
        #2;
        rst_n        = 1'b0;
        req_valid[0] = 1'b1;
        #1;
        chk("ar_ready", 64'(req_ready), 64'd0);
        chk("ar_rspv",  64'(rsp_valid), 64'd0);
        chk("ar_rspp",  64'(rsp_p),     64'd0);
        chk("ar_multa", 64'(mult_a),    64'd0);
        chk("ar_multb", 64'(mult_b),    64'd0);
        step();
        req_valid = '0;
        rst_n     = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("ar_stale", 64'(rsp_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule : tb_bmult8x8_arbiter
`default_nettype wire
